aurora_tx_lane: RTL and testbench
=================================

Name: aurora_tx_lane

Overview:
- Transmit-side Aurora 64b/66b lane, the counterpart of aurora_rx_lane.
- Accepts 66-bit blocks (2-bit sync header plus 64-bit payload) over a valid/ready handshake.
- Scrambles the payload with the self-synchronous x^58+x^39+1 polynomial and gearboxes the 66-bit blocks into a continuous 32-bit word stream for an external 32:1 serializer (OSERDES).
- Inserts idle blocks whenever the upstream has no data, so the serial stream never starves.

Parameters:
- IDLE_PAYLOAD, 64'h7800_0000_0000_0000, payload of the idle control block inserted on underflow.
- STAT_W, 16, width of the idle-insertion counter.

Ports:
- clk  in  1  lane word clock; one 32-bit word leaves per cycle.
- rst  in  1  synchronous, active-high reset.
- tx_data_i  in  64  payload, unscrambled.
- tx_header_i  in  2  sync header: 2'b01 data, 2'b10 control; 00/11 illegal.
- tx_valid_i  in  1  block on tx_data_i/tx_header_i is valid.
- tx_ready_o  out  1  lane accepts a block this cycle.
- tx_polarity_i  in  1  invert every output bit when 1.
- tx_data_o  out  32  gearbox word; bit 31 is serialized first.
- tx_idle_cnt_o  out  STAT_W  saturating count of inserted idle blocks.
- tx_hdr_err_o  out  1  one-cycle pulse when an accepted header is 00 or 11.

Behaviour:
- Reset, synchronous on rst=1:
  - fill=0, gearbox buffer=0, scrambler state=58'h3FF_FFFF_FFFF_FFFF (all ones).
  - tx_data_o=0, tx_ready_o=0, tx_idle_cnt_o=0, tx_hdr_err_o=0.
  - Any block in flight is discarded.
- Gearbox buffer:
  - 98-bit shift buffer plus a 7-bit fill count (0..97).
  - Valid bits are left-justified: bit 97 is the oldest.
- Ready:
  - tx_ready_o = (fill_q < 32) && !rst_q.
  - It is a function of registered state only, with no combinational path from tx_valid_i.
- Per-cycle update, applied in this order:
  1. Load. If fill_q < 32, one block is loaded.
     - If tx_valid_i=1 the input block is used and the handshake completes.
     - Otherwise an idle block {2'b10, IDLE_PAYLOAD} is used, tx_idle_cnt_o increments (saturating at all ones), and the scrambler still advances.
     - The loaded block {header, scrambled payload} is placed at bit positions [97-fill_q -: 66].
     - fill' = fill_q + 66.
  2. Emit. The top 32 bits are registered to tx_data_o (XOR with {32{tx_polarity_i}}), the buffer shifts left by 32, and fill_next = fill' - 32.
- Invariants:
  - fill' >= 32 every cycle, so no underflow and no bubble.
  - fill_q never exceeds 65; the buffer peak is 97.
- Rate:
  - Exactly 16 blocks are loaded per 33 cycles (1056 bits).
  - Starting from fill=0, the post-emit fill sequence is 34, 2, 36, 4, ... 30, 64, 32, 0, then the pattern repeats.
- Latency: the first header bit of a block accepted in cycle N appears at tx_data_o[31-fill_q] in cycle N+1.
- Scrambler:
  - Header bits are not scrambled.
  - Payload bits are processed i=0..63: s_i = d_i ^ S[38] ^ S[57]; then S = {S[56:0], s_i}.
  - The state advances only on loaded blocks, never on non-load cycles.
- Serial order: header[1], header[0], payload[63] down to payload[0], matching the receiver's MSB-first expectation.
- Header errors: an illegal header is still transmitted unmodified, and tx_hdr_err_o pulses for one cycle after acceptance.
- Polarity:
  - Applied only at the output register.
  - A toggle mid-stream takes effect on the next word and does not disturb the gearbox.
- Reset mid-operation: rst=1 for one cycle fully restarts the block.
  - The next block after release starts at tx_data_o bit 31.
  - tx_ready_o goes high in the second cycle after rst deasserts.

Decomposition:
- aurora_pkg:
  - Header constants HDR_DATA=2'b01, HDR_CTRL=2'b10.
  - IDLE block constant.
  - Scrambler taps SCR_TAP_A=38, SCR_TAP_B=57, SCR_W=58.
  - Typedef aurora_block_t as a packed struct {hdr[1:0], payload[63:0]}.
- Sub-module aurora_tx_scrambler:
  - Combinational 64-bit scramble step with a registered state.
  - Has an advance-enable input.
  - Is the inverse of the RX descrambler.

Test Plan:
- Continuous flow: tx_valid_i=1 with incrementing blocks {01, cnt, cnt} -> tx_ready_o high on exactly 16 of every 33 cycles, zero idles inserted, and aurora_rx_lane in loopback recovers every cnt in order.
- Starvation: tx_valid_i=0 for 100 cycles after reset -> continuous idle blocks; tx_idle_cnt_o = number of load cycles (49 after 100 cycles); the RX achieves block lock and never drops lock.
- Scrambler reference: scrambled payloads are compared bit-exactly against a bench model seeded with all ones, over 1000 random blocks including interleaved idles.
- Illegal header: a single block with header 2'b11 -> tx_hdr_err_o pulses once, and the bits '11' appear in the stream at the predicted offset.
- Polarity and reset: toggle tx_polarity_i mid-stream -> the next word is the bitwise inverse of the expected word. Assert rst for one cycle at fill=30 -> outputs are zero in that cycle, and the first post-reset block header lands at tx_data_o[31:30].
- Saturation: force 70000 idle loads with STAT_W=16 -> tx_idle_cnt_o holds at 16'hFFFF.

Source files
------------

// File: rtl/aurora_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aurora_pkg : shared constants and block type for the Aurora TX lane  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package aurora_pkg;

   localparam logic [1:0]  HDR_DATA         = 2'b01;
   localparam logic [1:0]  HDR_CTRL         = 2'b10;
   localparam logic [63:0] IDLE_PAYLOAD_DEF = 64'h7800_0000_0000_0000;

   localparam int SCR_TAP_A = 38;
   localparam int SCR_TAP_B = 57;
   localparam int SCR_W     = 58;

   typedef struct packed {
      logic [1:0]  hdr;
      logic [63:0] payload;
   } aurora_block_t;

   localparam aurora_block_t IDLE_BLOCK = '{hdr: HDR_CTRL, payload: IDLE_PAYLOAD_DEF};

   // Only 01 and 10 are legal sync headers.
   function automatic logic hdr_illegal(input logic [1:0] hdr);
      return (hdr[1] == hdr[0]);
   endfunction

endpackage
`default_nettype wire

// File: rtl/aurora_tx_scrambler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aurora_tx_scrambler : x^58+x^39+1 self-synchronous 64-bit scrambler  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module aurora_tx_scrambler
   import aurora_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        adv_i,
   input  logic [63:0] data_i,
   output logic [63:0] scr_o
);

   logic [SCR_W-1:0] state_q;
   logic [SCR_W-1:0] state_d;

   // Scrambled bits feed back into the state, payload bit 0 first.
   always_comb begin
      logic [SCR_W-1:0] st;
      st    = state_q;
      scr_o = '0;
      for (int i = 0; i < 64; i++) begin
         scr_o[i] = data_i[i] ^ st[SCR_TAP_A] ^ st[SCR_TAP_B];
         st       = {st[SCR_W-2:0], scr_o[i]};
      end
      state_d = st;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= '1;
      end else if (adv_i) begin
         state_q <= state_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/aurora_tx_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aurora_tx_lane : 64b/66b TX lane, scrambler + 66:32 gearbox + idles  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module aurora_tx_lane
   import aurora_pkg::*;
#(
   parameter logic [63:0] IDLE_PAYLOAD = IDLE_PAYLOAD_DEF,
   parameter int unsigned STAT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [63:0]       tx_data_i,
   input  logic [1:0]        tx_header_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   input  logic              tx_polarity_i,
   output logic [31:0]       tx_data_o,
   output logic [STAT_W-1:0] tx_idle_cnt_o,
   output logic              tx_hdr_err_o
);

   logic [97:0]       buf_q, buf_d, load_buf;
   logic [6:0]        fill_q, fill_d, fill_ld;
   logic [31:0]       data_q, data_d;
   logic [STAT_W-1:0] idle_q, idle_d;
   logic              err_q, err_d;
   logic              rst_q;
   logic              load;
   aurora_block_t     blk;
   aurora_block_t     blk_scr;
   logic [63:0]       scr_payload;

   // The cycle right after reset release loads nothing so the stream restarts cleanly.
   assign load       = (fill_q < 7'd32) && !rst_q;
   assign tx_ready_o = load;

   always_comb begin
      if (tx_valid_i) begin
         blk = '{hdr: tx_header_i, payload: tx_data_i};
      end else begin
         blk = '{hdr: HDR_CTRL, payload: IDLE_PAYLOAD};
      end
   end

   aurora_tx_scrambler u_scrambler (
      .clk    (clk),
      .rst    (rst),
      .adv_i  (load),
      .data_i (blk.payload),
      .scr_o  (scr_payload)
   );

   assign blk_scr = '{hdr: blk.hdr, payload: scr_payload};

   always_comb begin
      load_buf = buf_q;
      fill_ld  = fill_q;
      if (load) begin
         // Block lands directly behind the valid bits: [97-fill_q -: 66].
         load_buf = buf_q | ({32'd0, blk_scr} << (7'd32 - fill_q));
         fill_ld  = fill_q + 7'd66;
      end
      buf_d  = load_buf << 32;
      fill_d = (fill_ld >= 7'd32) ? (fill_ld - 7'd32) : 7'd0;
      data_d = load_buf[97:66] ^ {32{tx_polarity_i}};
      err_d  = load && tx_valid_i && hdr_illegal(tx_header_i);
      idle_d = idle_q;
      if (load && !tx_valid_i && (idle_q != {STAT_W{1'b1}})) begin
         idle_d = idle_q + STAT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      rst_q <= rst;
      if (rst) begin
         buf_q  <= '0;
         fill_q <= '0;
         data_q <= '0;
         idle_q <= '0;
         err_q  <= 1'b0;
      end else begin
         buf_q  <= buf_d;
         fill_q <= fill_d;
         data_q <= data_d;
         idle_q <= idle_d;
         err_q  <= err_d;
      end
   end

   assign tx_data_o     = data_q;
   assign tx_idle_cnt_o = idle_q;
   assign tx_hdr_err_o  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_aurora_tx_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_aurora_tx_lane : self-checking bench with a bit-queue lane model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_aurora_tx_lane;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] tx_data_i = '0;
   logic [1:0]  tx_header_i = 2'b01;
   logic        tx_valid_i = 1'b0;
   logic        tx_polarity_i = 1'b0;
   logic        tx_ready_o;
   logic [31:0] tx_data_o;
   logic [15:0] tx_idle_cnt_o;
   logic        tx_hdr_err_o;

   logic        s_ready;
   logic [31:0] s_data;
   logic [7:0]  s_idle;
   logic        s_err;

   always #5 clk = ~clk;

   aurora_tx_lane #(.STAT_W(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .tx_data_i     (tx_data_i),
      .tx_header_i   (tx_header_i),
      .tx_valid_i    (tx_valid_i),
      .tx_ready_o    (tx_ready_o),
      .tx_polarity_i (tx_polarity_i),
      .tx_data_o     (tx_data_o),
      .tx_idle_cnt_o (tx_idle_cnt_o),
      .tx_hdr_err_o  (tx_hdr_err_o)
   );

   // Narrow-counter instance kept permanently starved to reach saturation quickly.
   aurora_tx_lane #(.STAT_W(8)) dut_sat (
      .clk           (clk),
      .rst           (rst),
      .tx_data_i     (64'd0),
      .tx_header_i   (2'b01),
      .tx_valid_i    (1'b0),
      .tx_ready_o    (s_ready),
      .tx_polarity_i (1'b0),
      .tx_data_o     (s_data),
      .tx_idle_cnt_o (s_idle),
      .tx_hdr_err_o  (s_err)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: serial bit queue ----------------
   bit          mq[$];
   logic [57:0] mscr;
   logic        m_rstq;
   logic [31:0] m_data, m_raw;
   int          m_idle;
   logic        m_err;
   logic        dut_ready_seen;

   function automatic logic [63:0] m_scramble(input logic [63:0] d);
      logic [63:0] s;
      for (int i = 0; i < 64; i++) begin
         s[i] = d[i] ^ mscr[38] ^ mscr[57];
         mscr = {mscr[56:0], s[i]};
      end
      return s;
   endfunction

   task automatic model_step(input logic rv, input logic v, input logic [1:0] h,
                             input logic [63:0] d, input logic p);
      logic [63:0] s;
      logic [63:0] bd;
      logic [1:0]  bh;
      logic        ld;
      if (rv) begin
         mq.delete();
         mscr   = '1;
         m_rstq = 1'b1;
         m_data = '0;
         m_raw  = '0;
         m_idle = 0;
         m_err  = 1'b0;
         return;
      end
      ld    = (mq.size() < 32) && !m_rstq;
      m_err = 1'b0;
      if (ld) begin
         if (v) begin
            bh    = h;
            bd    = d;
            m_err = (h == 2'b00) || (h == 2'b11);
         end else begin
            bh = 2'b10;
            bd = 64'h7800_0000_0000_0000;
            if (m_idle < 65535) m_idle++;
         end
         s = m_scramble(bd);
         mq.push_back(bh[1]);
         mq.push_back(bh[0]);
         for (int i = 63; i >= 0; i--) mq.push_back(s[i]);
      end
      for (int b = 31; b >= 0; b--) m_raw[b] = (mq.size() > 0) ? mq.pop_front() : 1'b0;
      m_data = m_raw ^ {32{p}};
      m_rstq = 1'b0;
   endtask

   task automatic cycle(input logic rv, input logic v, input logic [1:0] h,
                        input logic [63:0] d, input logic p);
      logic m_ready;
      rst           = rv;
      tx_valid_i    = v;
      tx_header_i   = h;
      tx_data_i     = d;
      tx_polarity_i = p;
      m_ready        = (mq.size() < 32) && !m_rstq;
      dut_ready_seen = tx_ready_o;
      chk("ready", {63'd0, tx_ready_o}, {63'd0, m_ready});
      @(posedge clk);
      model_step(rv, v, h, d, p);
      #1;
      chk("data", {32'd0, tx_data_o}, {32'd0, m_data});
      chk("idle_cnt", {48'd0, tx_idle_cnt_o}, 64'(m_idle));
      chk("hdr_err", {63'd0, tx_hdr_err_o}, {63'd0, m_err});
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       rv;
      logic       v;
      logic [1:0] h;
      logic       exp_ready;
      int         exp_idle;
      logic       exp_err;
      int         hpos;
      logic [1:0] exp_hdr;
      logic       exp_zero;
   } vec_t;

   function automatic vec_t mk(logic rv, logic v, logic [1:0] h, logic er, int ei,
                               logic ee, int hp, logic [1:0] eh, logic ez);
      vec_t t;
      t.rv = rv; t.v = v; t.h = h; t.exp_ready = er; t.exp_idle = ei;
      t.exp_err = ee; t.hpos = hp; t.exp_hdr = eh; t.exp_zero = ez;
      return t;
   endfunction

   vec_t tbl[13];

   initial begin
      logic [31:0] w;
      logic [31:0] cnt;
      int          nready;
      int          accepted;
      int          guard;
      logic        pol;
      logic [1:0]  h;
      int          r;

      tbl[0]  = mk(0, 0, 2'b01, 0, 0, 0, -1, 2'b00, 0);
      tbl[1]  = mk(0, 1, 2'b01, 1, 0, 0, 31, 2'b01, 0);
      tbl[2]  = mk(0, 0, 2'b01, 0, 0, 0, -1, 2'b00, 0);
      tbl[3]  = mk(0, 0, 2'b01, 1, 1, 0, 29, 2'b10, 0);
      tbl[4]  = mk(0, 1, 2'b11, 0, 1, 0, -1, 2'b00, 0);
      tbl[5]  = mk(0, 1, 2'b11, 1, 1, 1, 27, 2'b11, 0);
      tbl[6]  = mk(0, 0, 2'b01, 0, 1, 0, -1, 2'b00, 0);
      tbl[7]  = mk(0, 1, 2'b00, 1, 1, 1, 25, 2'b00, 0);
      tbl[8]  = mk(0, 1, 2'b10, 0, 1, 0, -1, 2'b00, 0);
      tbl[9]  = mk(0, 1, 2'b10, 1, 1, 0, 23, 2'b10, 0);
      tbl[10] = mk(1, 0, 2'b01, 0, 0, 0, -1, 2'b00, 1);
      tbl[11] = mk(0, 1, 2'b01, 0, 0, 0, -1, 2'b00, 1);
      tbl[12] = mk(0, 1, 2'b01, 1, 0, 0, 31, 2'b01, 0);

      // Initial reset: DUT registers are unknown until the first edges.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      model_step(1'b1, 1'b0, 2'b01, 64'd0, 1'b0);
      #1;
      cycle(1'b1, 1'b0, 2'b01, 64'd0, 1'b0);
      chk("reset_data", {32'd0, tx_data_o}, 64'd0);
      chk("reset_idle", {48'd0, tx_idle_cnt_o}, 64'd0);

      for (int i = 0; i < 13; i++) begin
         cycle(tbl[i].rv, tbl[i].v, tbl[i].h, {$urandom, $urandom}, 1'b0);
         chk("tbl_ready", {63'd0, dut_ready_seen}, {63'd0, tbl[i].exp_ready});
         chk("tbl_idle", {48'd0, tx_idle_cnt_o}, 64'(tbl[i].exp_idle));
         chk("tbl_err", {63'd0, tx_hdr_err_o}, {63'd0, tbl[i].exp_err});
         w = tx_data_o;
         if (tbl[i].hpos >= 0) chk("tbl_hdr_pos", {62'd0, w[tbl[i].hpos -: 2]}, {62'd0, tbl[i].exp_hdr});
         if (tbl[i].exp_zero) chk("tbl_zero", {32'd0, w}, 64'd0);
      end

      // Continuous flow from fill 0: 16 loads per 33 cycles, no idles.
      cycle(1'b1, 1'b0, 2'b01, 64'd0, 1'b0);
      cycle(1'b0, 1'b1, 2'b01, 64'd0, 1'b0);
      cnt    = 32'd0;
      nready = 0;
      for (int i = 0; i < 66; i++) begin
         cycle(1'b0, 1'b1, 2'b01, {cnt, cnt}, 1'b0);
         if (dut_ready_seen) begin
            nready++;
            cnt++;
         end
      end
      chk("flow_ready_cnt", 64'(nready), 64'd32);
      chk("flow_no_idle", {48'd0, tx_idle_cnt_o}, 64'd0);

      // Reset when fill is 30; first post-reset header lands at [31:30].
      guard = 0;
      while (mq.size() != 30 && guard < 40) begin
         cycle(1'b0, 1'b1, 2'b01, {cnt, cnt}, 1'b0);
         if (dut_ready_seen) cnt++;
         guard++;
      end
      chk("reach_fill30", 64'(mq.size()), 64'd30);
      cycle(1'b1, 1'b1, 2'b01, 64'hDEAD_BEEF_0000_0001, 1'b0);
      chk("rst_zero", {32'd0, tx_data_o}, 64'd0);
      cycle(1'b0, 1'b1, 2'b01, 64'hDEAD_BEEF_0000_0001, 1'b0);
      chk("rst_release_no_ready", {63'd0, dut_ready_seen}, 64'd0);
      cycle(1'b0, 1'b1, 2'b01, 64'hDEAD_BEEF_0000_0001, 1'b0);
      chk("rst_ready2", {63'd0, dut_ready_seen}, 64'd1);
      chk("rst_hdr_top", {62'd0, tx_data_o[31:30]}, 64'd1);

      // Polarity toggle affects only the next word.
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 2'b01, {$urandom, $urandom}, 1'b0);
      cycle(1'b0, 1'b1, 2'b01, {$urandom, $urandom}, 1'b1);
      chk("pol_inverted", {32'd0, tx_data_o}, {32'd0, ~m_raw});
      cycle(1'b0, 1'b1, 2'b01, {$urandom, $urandom}, 1'b0);
      chk("pol_restored", {32'd0, tx_data_o}, {32'd0, m_raw});

      // Starvation: 100 idle cycles after reset release.
      cycle(1'b1, 1'b0, 2'b01, 64'd0, 1'b0);
      cycle(1'b0, 1'b0, 2'b01, 64'd0, 1'b0);
      for (int i = 0; i < 100; i++) cycle(1'b0, 1'b0, 2'b01, 64'd0, 1'b0);
      chk("starve_idle", {48'd0, tx_idle_cnt_o}, 64'd49);
      chk("starve_idle_sat_inst", {56'd0, s_idle}, 64'd49);

      // Random traffic against the model, 1000 accepted blocks.
      accepted = 0;
      guard    = 0;
      pol      = 1'b0;
      while (accepted < 1000 && guard < 4000) begin
         r = $urandom_range(0, 19);
         if (r == 0)      h = 2'b00;
         else if (r == 1) h = 2'b11;
         else             h = r[0] ? 2'b01 : 2'b10;
         if ($urandom_range(0, 49) == 0) pol = ~pol;
         cycle(1'b0, ($urandom_range(0, 9) < 8), h, {$urandom, $urandom}, pol);
         if (dut_ready_seen && tx_valid_i) accepted++;
         guard++;
      end
      chk("rand_blocks_done", 64'(accepted >= 1000), 64'd1);

      chk("sat_idle", {56'd0, s_idle}, 64'hFF);
      cycle(1'b0, 1'b0, 2'b01, 64'd0, 1'b0);
      cycle(1'b0, 1'b0, 2'b01, 64'd0, 1'b0);
      chk("sat_idle_hold", {56'd0, s_idle}, 64'hFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
